// File: rtl/clock_ctrl_pkg.sv
// Shared encodings for the front-panel time-set controller: FSM states, BCD field limits
// and the counter speed codes.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StSetH   = 3'd1,
        StSetM   = 3'd2,
        StSetS   = 3'd3,
        StCommit = 3'd4
    } state_e;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    localparam logic [1:0] SPD_X1   = 2'b00;
    localparam logic [1:0] SPD_X10  = 2'b01;
    localparam logic [1:0] SPD_X100 = 2'b10;
    localparam logic [1:0] SPD_X200 = 2'b11;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Bundle of button pulses, current time and load/display outputs between the panel
// controller (slave) and its surroundings (master).
interface clock_set_ctrl_if;

    logic       tick;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic       btn_spd;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] cur_sec;

    logic       run_en;
    logic       load;
    logic [7:0] load_hour;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [1:0] time_spd;
    logic [2:0] blink_mask;

    modport master (
        output tick, btn_mode, btn_up, btn_down, btn_spd, cur_hour, cur_min, cur_sec,
        input  run_en, load, load_hour, load_min, load_sec, time_spd, blink_mask
    );

    modport slave (
        input  tick, btn_mode, btn_up, btn_down, btn_spd, cur_hour, cur_min, cur_sec,
        output run_en, load, load_hour, load_min, load_sec, time_spd, blink_mask
    );

endinterface

// File: rtl/bcd_field_step.sv
// Combinational +/-1 step of a two-digit BCD field with wrap-around at 00/max.
// An invalid value snaps to 00 on up and to max on down.
module bcd_field_step (
    input  logic [7:0] value,
    input  logic [7:0] max,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next_value
);

    logic [3:0] hi;
    logic [3:0] lo;
    logic       valid;

    always_comb begin
        hi         = value[7:4];
        lo         = value[3:0];
        // Valid BCD digits keep numeric order, so a plain compare against max works.
        valid      = (hi <= 4'd9) && (lo <= 4'd9) && (value <= max);
        next_value = value;
        if (up && !down) begin
            if (!valid || value == max) begin
                next_value = 8'h00;
            end else if (lo == 4'd9) begin
                next_value = {hi + 4'd1, 4'd0};
            end else begin
                next_value = {hi, lo + 4'd1};
            end
        end else if (down && !up) begin
            if (!valid || value == 8'h00) begin
                next_value = max;
            end else if (lo == 4'd0) begin
                next_value = {hi - 4'd1, 4'd9};
            end else begin
                next_value = {hi, lo - 4'd1};
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel edit sequencer: shadows the counter time, edits hour/min/sec by buttons,
// commits with a one-cycle load strobe, and handles timeout, speed select and blinking.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned BLINK_HALF    = 2
) (
    input logic             clk,
    input logic             rst,
    clock_set_ctrl_if.slave bus
);

    localparam int unsigned ToW = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned BlW = $clog2(BLINK_HALF + 1);

    state_e           state_q, state_d;
    logic [1:0]       spd_q, spd_d;
    logic [7:0]       hour_q, hour_d;
    logic [7:0]       min_q, min_d;
    logic [7:0]       sec_q, sec_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [BlW-1:0]   bl_cnt_q, bl_cnt_d;
    logic             bl_q, bl_d;
    logic             run_en_q, run_en_d;
    logic             load_q, load_d;
    logic [2:0]       mask_q, mask_d;

    logic [7:0]       sel_val;
    logic [7:0]       sel_max;
    logic [7:0]       step_val;
    logic             any_btn;
    logic             step_en;

    always_comb begin
        sel_val = hour_q;
        sel_max = HOUR_MAX;
        case (state_q)
            StSetM:  begin sel_val = min_q; sel_max = MIN_MAX; end
            StSetS:  begin sel_val = sec_q; sel_max = SEC_MAX; end
            default: begin sel_val = hour_q; sel_max = HOUR_MAX; end
        endcase
    end

    bcd_field_step u_step (
        .value      (sel_val),
        .max        (sel_max),
        .up         (bus.btn_up),
        .down       (bus.btn_down),
        .next_value (step_val)
    );

    always_comb begin
        state_d  = state_q;
        spd_d    = spd_q;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        to_d     = to_q;
        bl_cnt_d = bl_cnt_q;
        bl_d     = bl_q;
        any_btn  = bus.btn_mode | bus.btn_up | bus.btn_down | bus.btn_spd;
        step_en  = !bus.btn_mode && (bus.btn_up ^ bus.btn_down);

        case (state_q)
            StRun: begin
                if (bus.btn_mode) begin
                    hour_d  = bus.cur_hour;
                    min_d   = bus.cur_min;
                    sec_d   = bus.cur_sec;
                    state_d = StSetH;
                end
                if (bus.btn_spd) begin
                    spd_d = spd_q + 2'd1;
                end
            end
            StSetH, StSetM, StSetS: begin
                if (bus.btn_mode) begin
                    state_d = (state_q == StSetH) ? StSetM :
                              (state_q == StSetM) ? StSetS : StCommit;
                end else if (step_en) begin
                    if (state_q == StSetH)      hour_d = step_val;
                    else if (state_q == StSetM) min_d  = step_val;
                    else                        sec_d  = step_val;
                end
                // A press coinciding with the expiring tick wins over the timeout.
                if (any_btn) begin
                    to_d = '0;
                end else if (bus.tick) begin
                    if (to_q == ToW'(TIMEOUT_TICKS - 1)) state_d = StRun;
                    else                                 to_d = to_q + ToW'(1);
                end
                if (bus.btn_up || bus.btn_down) begin
                    bl_cnt_d = '0;
                    bl_d     = 1'b0;
                end else if (bus.tick) begin
                    if (bl_cnt_q == BlW'(BLINK_HALF - 1)) begin
                        bl_cnt_d = '0;
                        bl_d     = ~bl_q;
                    end else begin
                        bl_cnt_d = bl_cnt_q + BlW'(1);
                    end
                end
            end
            StCommit: state_d = StRun;
            default:  state_d = StRun;
        endcase

        if (state_d != state_q) begin
            to_d     = '0;
            bl_cnt_d = '0;
            bl_d     = 1'b0;
        end

        run_en_d = (state_d == StRun);
        load_d   = (state_d == StCommit);
        case (state_d)
            StSetH:  mask_d = {bl_d, 2'b00};
            StSetM:  mask_d = {1'b0, bl_d, 1'b0};
            StSetS:  mask_d = {2'b00, bl_d};
            default: mask_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StRun;
            spd_q    <= SPD_X1;
            hour_q   <= 8'h00;
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            to_q     <= '0;
            bl_cnt_q <= '0;
            bl_q     <= 1'b0;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            mask_q   <= 3'b000;
        end else begin
            state_q  <= state_d;
            spd_q    <= spd_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            to_q     <= to_d;
            bl_cnt_q <= bl_cnt_d;
            bl_q     <= bl_d;
            run_en_q <= run_en_d;
            load_q   <= load_d;
            mask_q   <= mask_d;
        end
    end

    assign bus.run_en     = run_en_q;
    assign bus.load       = load_q;
    assign bus.load_hour  = hour_q;
    assign bus.load_min   = min_q;
    assign bus.load_sec   = sec_q;
    assign bus.time_spd   = spd_q;
    assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: expectations are queued as stimulus is applied and
// drained against the DUT one cycle later.
module tb_clock_set_ctrl;

    logic clk;
    logic rst;
    clock_set_ctrl_if bus ();

    clock_set_ctrl #(
        .TIMEOUT_TICKS (30),
        .BLINK_HALF    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    int          load_pulses;
    int          exp_loads;

    always @(negedge clk) if (bus.load === 1'b1) load_pulses++;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [31:0] obs_of(input string tag);
        case (tag)
            "run_en": return {31'd0, bus.run_en};
            "load":   return {31'd0, bus.load};
            "hour":   return {24'd0, bus.load_hour};
            "min":    return {24'd0, bus.load_min};
            "sec":    return {24'd0, bus.load_sec};
            "spd":    return {30'd0, bus.time_spd};
            "mask":   return {29'd0, bus.blink_mask};
            "loads":  return load_pulses;
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs_of(e.tag);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic drive(input logic m, input logic u, input logic d, input logic s,
                         input logic t);
        bus.btn_mode = m;
        bus.btn_up   = u;
        bus.btn_down = d;
        bus.btn_spd  = s;
        bus.tick     = t;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.btn_spd  = 1'b0;
        bus.tick     = 1'b0;
    endtask

    task automatic mode();  drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic up();    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
    task automatic down();  drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
    task automatic spd();   drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic tick();  drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
    task automatic idle();  drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

    task automatic commit_and_settle();
        mode(); mode(); mode();
        expect_val("load", 1);
        drain();
        idle();
        exp_loads++;
        expect_val("load", 0);
        expect_val("run_en", 1);
        drain();
        idle();
        expect_val("loads", exp_loads);
        drain();
    endtask

    initial begin
        checks = 0; errors = 0; load_pulses = 0; exp_loads = 0;
        bus.tick = 0; bus.btn_mode = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_spd = 0;
        bus.cur_hour = 8'h12; bus.cur_min = 8'h34; bus.cur_sec = 8'h56;
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        expect_val("run_en", 1); expect_val("load", 0); expect_val("spd", 0);
        expect_val("hour", 0); expect_val("min", 0); expect_val("sec", 0);
        expect_val("mask", 0);
        drain();
        rst = 1'b1;
        idle();

        // Capture and blink.
        mode();
        expect_val("run_en", 0); expect_val("hour", 8'h12); expect_val("min", 8'h34);
        expect_val("sec", 8'h56); expect_val("mask", 3'b000);
        drain();
        tick(); expect_val("mask", 3'b000); drain();
        tick(); expect_val("mask", 3'b100); drain();
        tick(); expect_val("mask", 3'b100); drain();
        tick(); expect_val("mask", 3'b000); drain();
        tick(); tick(); expect_val("mask", 3'b100); drain();

        // Hour wrap both ways; up forces blink bit low.
        for (int i = 0; i < 11; i++) up();
        expect_val("hour", 8'h23); expect_val("mask", 3'b000); drain();
        up();   expect_val("hour", 8'h00); drain();
        down(); expect_val("hour", 8'h23); drain();

        // Minute wrap at 59.
        mode(); expect_val("min", 8'h34); expect_val("mask", 3'b000); drain();
        for (int i = 0; i < 25; i++) up();
        expect_val("min", 8'h59); drain();
        up(); expect_val("min", 8'h00); drain();
        mode(); mode();
        expect_val("load", 1); expect_val("run_en", 0); expect_val("hour", 8'h23);
        expect_val("min", 8'h00); expect_val("sec", 8'h56);
        drain();
        idle(); exp_loads++;
        expect_val("load", 0); expect_val("run_en", 1); drain();
        idle(); expect_val("loads", exp_loads); drain();

        // Full edit to 13:33:56.
        mode(); up(); mode(); down(); mode(); mode();
        expect_val("load", 1); expect_val("run_en", 0); expect_val("hour", 8'h13);
        expect_val("min", 8'h33); expect_val("sec", 8'h56);
        drain();
        idle(); exp_loads++;
        expect_val("load", 0); expect_val("run_en", 1); drain();
        idle(); expect_val("loads", exp_loads); drain();

        // Timeout after 30 idle ticks, no load.
        mode();
        for (int i = 0; i < 29; i++) tick();
        expect_val("run_en", 0); drain();
        tick(); expect_val("run_en", 1); expect_val("load", 0); drain();
        idle(); expect_val("loads", exp_loads); drain();

        // Press on the 30th tick restarts the timeout.
        mode();
        for (int i = 0; i < 29; i++) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_val("run_en", 0); expect_val("hour", 8'h13); drain();
        for (int i = 0; i < 29; i++) tick();
        expect_val("run_en", 0); drain();
        tick(); expect_val("run_en", 1); drain();
        idle(); expect_val("loads", exp_loads); drain();

        // Speed cycling in RUN, ignored in SET_M.
        spd(); expect_val("spd", 2'b01); drain();
        spd(); expect_val("spd", 2'b10); drain();
        spd(); expect_val("spd", 2'b11); drain();
        spd(); expect_val("spd", 2'b00); drain();
        spd(); expect_val("spd", 2'b01); drain();
        mode(); mode();
        spd(); expect_val("spd", 2'b01); expect_val("min", 8'h34); drain();
        tick(); tick(); expect_val("mask", 3'b010); drain();
        mode(); mode();
        expect_val("load", 1); drain();
        idle(); exp_loads++;
        expect_val("load", 0); expect_val("run_en", 1); drain();

        // Invalid BCD hour, simultaneous presses, reset mid-edit.
        bus.cur_hour = 8'h2A;
        mode(); expect_val("hour", 8'h2A); drain();
        up();   expect_val("hour", 8'h00); drain();
        commit_and_settle();
        mode(); expect_val("hour", 8'h2A); drain();
        down(); expect_val("hour", 8'h23); drain();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_val("hour", 8'h23); drain();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_val("hour", 8'h23); expect_val("min", 8'h34); expect_val("mask", 3'b000);
        drain();
        mode();
        rst = 1'b0;
        idle();
        expect_val("run_en", 1); expect_val("load", 0); expect_val("spd", 0);
        expect_val("hour", 0); expect_val("min", 0); expect_val("sec", 0);
        expect_val("mask", 0);
        drain();
        rst = 1'b1;
        idle(); idle();
        expect_val("load", 0); expect_val("run_en", 1); expect_val("loads", exp_loads);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
